// File: rtl/fixed_power_calc.sv
// Q(W-FRAC).FRAC power stage: pairs I/V words, multiplies them with a
// sequential signed shift-add unit and returns P = I*V with an overflow flag.
// Ports: CLK, RST_PW (full sync reset), RST_FSM_PW (FSM-only sync reset),
//        I_FX/ACK_I, V_FX/ACK_V operand words and strobes,
//        RESULT_P, ACK_P (result valid), O_F (overflow).
// Build option: define PW_SATURATE_EN to clamp overflowed results instead of
// wrapping them.
module fixed_power_calc #(
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic         CLK,
  input  logic         RST_PW,
  input  logic         RST_FSM_PW,
  input  logic [W-1:0] I_FX,
  input  logic         ACK_I,
  input  logic [W-1:0] V_FX,
  input  logic         ACK_V,
  output logic [W-1:0] RESULT_P,
  output logic         ACK_P,
  output logic         O_F
);

  localparam int CW = $clog2(W) + 1;

  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    MUL,
    NORM,
    DONE
  } state_t;

  state_t         state;
  logic           ack_i_d;
  logic           ack_v_d;
  logic           got_i;
  logic           got_v;
  logic [W-1:0]   op_i;
  logic [W-1:0]   op_v;
  logic [W-1:0]   mcand;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;
  logic           neg;

  logic           edge_i;
  logic           edge_v;
  logic [W-1:0]   mag_i;
  logic [W-1:0]   mag_v;
  logic [W:0]     sum;
  logic [W-1:0]   mag;
  logic [W-FRAC-1:0] hi;
  logic           ovf;
  logic [W-1:0]   neg_mag;
  logic [W-1:0]   wrap;
  logic [W-1:0]   res;

  assign edge_i = ACK_I & ~ack_i_d;
  assign edge_v = ACK_V & ~ack_v_d;

  // Unsigned magnitudes: the most negative word maps onto 2^(W-1).
  assign mag_i = op_i[W-1] ? (~op_i + {{(W-1){1'b0}}, 1'b1}) : op_i;
  assign mag_v = op_v[W-1] ? (~op_v + {{(W-1){1'b0}}, 1'b1}) : op_v;

  // Partial product lives in the upper half; the multiplier is consumed
  // from the lower half LSB first as the accumulator shifts right.
  assign sum = {1'b0, acc[2*W-1:W]}
             + (acc[0] ? {1'b0, mcand} : {(W+1){1'b0}});

  assign mag     = acc[W+FRAC-1:FRAC];
  assign hi      = acc[2*W-1:W+FRAC];
  assign ovf     = (|hi) | (neg ? (mag > MIN_NEG) : (mag > MAX_POS));
  assign neg_mag = ~mag + {{(W-1){1'b0}}, 1'b1};
  assign wrap    = neg ? neg_mag : mag;

`ifdef PW_SATURATE_EN
  assign res = ovf ? (neg ? MIN_NEG : MAX_POS) : wrap;
`else
  assign res = wrap;
`endif

  always_ff @(posedge CLK) begin
    if (RST_PW) begin
      state    <= IDLE;
      ack_i_d  <= 1'b0;
      ack_v_d  <= 1'b0;
      got_i    <= 1'b0;
      got_v    <= 1'b0;
      op_i     <= '0;
      op_v     <= '0;
      mcand    <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      RESULT_P <= '0;
      ACK_P    <= 1'b0;
      O_F      <= 1'b0;
    end else begin
      ack_i_d <= ACK_I;
      ack_v_d <= ACK_V;
      if (RST_FSM_PW) begin
        state <= IDLE;
        got_i <= 1'b0;
        got_v <= 1'b0;
        ACK_P <= 1'b0;
        O_F   <= 1'b0;
      end else begin
        unique case (state)
          IDLE, WAIT: begin
            if (got_i && got_v) begin
              state <= MUL;
              ACK_P <= 1'b0;
              O_F   <= 1'b0;
              mcand <= mag_i;
              acc   <= {{W{1'b0}}, mag_v};
              cnt   <= '0;
              neg   <= op_i[W-1] ^ op_v[W-1];
            end else begin
              if (edge_i) begin
                op_i  <= I_FX;
                got_i <= 1'b1;
              end
              if (edge_v) begin
                op_v  <= V_FX;
                got_v <= 1'b1;
              end
              if (edge_i || edge_v || got_i || got_v)
                state <= WAIT;
            end
          end
          MUL: begin
            acc <= {sum, acc[W-1:1]};
            cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
            if (cnt == CW'(W-1))
              state <= NORM;
          end
          NORM: begin
            RESULT_P <= res;
            O_F      <= ovf;
            ACK_P    <= 1'b1;
            state    <= DONE;
          end
          DONE: begin
            got_i <= 1'b0;
            got_v <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/fixed_power_calc.md
# fixed_power_calc

Fixed-point power stage downstream of the linearizer/normalizer: takes the normalized current and voltage words with their completion strobes, pairs them and multiplies them with a sequential signed shift-add multiplier. It returns P = I·V in the same fixed-point format, with a completion flag and an overflow flag. It feeds the MPPT/control logic that consumes panel power.

## Interface
- W, 32, word width of I, V and P (two's complement)
- FRAC, 16, fractional bits of the shared fixed-point format (Q(W-FRAC).FRAC)

- CLK  in  1  system clock; single clock domain
- RST_PW  in  1  synchronous, active-high reset; clears everything
- RST_FSM_PW  in  1  synchronous, active-high FSM reset; clears state, capture flags, ACK_P, O_F; RESULT_P is retained
- I_FX  in  W  normalized current word
- ACK_I  in  1  current-word valid/done strobe; pulse or level
- V_FX  in  W  normalized voltage word
- ACK_V  in  1  voltage-word valid/done strobe; pulse or level
- RESULT_P  out  W  power word, same format as the inputs
- ACK_P  out  1  result valid; held high until the next operation starts or a reset
- O_F  out  1  overflow flag for the current result

## Operation
- Rising-edge detection on ACK_I and ACK_V:
  - A registered copy of each strobe is kept.
  - An edge is `ACK_x & ~ACK_x_d`, so level-held strobes count once.
- Capture:
  - In IDLE or WAIT, an ACK_I edge loads I_FX into op_i and sets got_i. ACK_V does the same into op_v/got_v.
  - A repeated edge from an already-captured source overwrites that operand.
  - Simultaneous edges capture both operands in the same cycle.
- States:
  - IDLE: no operand held. ACK_P keeps its last value.
  - WAIT: exactly one operand held.
  - MUL: multiplication in progress.
  - NORM: scaling, overflow check and sign restoration.
  - DONE: result presented.
- Transitions:
  - IDLE → WAIT when one operand is captured.
  - IDLE/WAIT → MUL when both got_i and got_v are set. On entry, ACK_P and O_F clear.
  - DONE → IDLE on the next cycle. The capture flags clear, while ACK_P and RESULT_P hold.
- MUL:
  - Operates on magnitudes. The result sign is sign(op_i) XOR sign(op_v).
  - Each cycle examines one multiplier bit, LSB first: conditional add of the multiplicand, then a right shift into a 2W accumulator.
  - Runs exactly W iterations, tracked by an iteration counter of ceil(log2 W)+1 bits.
  - |−2^(W−1)| is treated as 2^(W−1), using an unsigned W-bit magnitude.
- NORM:
  - The scaled magnitude is acc[W+FRAC-1:FRAC]; bits below FRAC are truncated toward zero.
  - Overflow is set when acc[2W-1:W+FRAC] ≠ 0, or when the scaled magnitude exceeds 2^(W−1)−1 (positive) or 2^(W−1) (negative).
  - The result is negated if the sign is set. O_F takes the overflow value.
- Busy period (MUL/NORM): edges on ACK_I/ACK_V are ignored and their data dropped. An upstream word arriving while busy needs a fresh edge after DONE.
- Zero operand: computed normally and gives 0 with O_F=0. No early exit.

## Timing
- Cycle 0 is the cycle in which the second operand edge is sampled.
  - Cycles 1..W: MUL.
  - Cycle W+1: NORM.
  - Cycle W+2: DONE. RESULT_P and ACK_P=1 are visible; latency is W+2 cycles (34 for W=32).
- ACK_P rises in DONE and stays high until the cycle after the next transition into MUL, RST_PW or RST_FSM_PW.
- Reset values after RST_PW: RESULT_P=0, ACK_P=0, O_F=0, state IDLE, got_i=got_v=0, edge registers=0.
- RST_FSM_PW mid-operation:
  - Aborts MUL/NORM on the next edge and returns to IDLE.
  - RESULT_P keeps the previous completed value. ACK_P=0, O_F=0.
- RST_PW has priority over RST_FSM_PW. Both have priority over capture in the same cycle.

## Configuration
- PW_SATURATE_EN defined: on overflow, RESULT_P clamps to 0x7FFF_FFFF (positive) or 0x8000_0000 (negative), with O_F=1.
- PW_SATURATE_EN undefined: RESULT_P is the low W bits of the signed scaled product (wrap), with O_F=1.
- O_F detection is identical in both builds.

## Test plan
Values below are for W=32, FRAC=16.
- I_FX=0x00020000 (2.0) with ACK_I pulse; 5 cycles later V_FX=0x00038000 (3.5) with ACK_V pulse → RESULT_P=0x00070000, O_F=0, ACK_P rises exactly 34 cycles after the ACK_V edge.
- ACK_V before ACK_I, with I=0xFFFE8000 (−1.5) and V=0x00020000 (2.0), both strobes level-held → RESULT_P=0xFFFD0000, exactly one computation, ACK_P held.
- Simultaneous ACK_I/ACK_V edges with 0x01000000 (256.0) each → O_F=1. RESULT_P=0x7FFFFFFF with PW_SATURATE_EN; 0x00000000 without it.
- RST_FSM_PW asserted at cycle 10 of MUL after a prior result 0x00070000 → ACK_P=0, O_F=0, RESULT_P still 0x00070000, state IDLE. A fresh pair then completes normally.
- ACK_I edge during MUL with a new value → ignored; the result reflects the original operands, and the FSM returns to IDLE with got_i=0.
- I=0x80000000 (−32768.0), V=0xFFFF0000 (−1.0) → overflow positive: O_F=1, RESULT_P=0x7FFFFFFF with PW_SATURATE_EN.
